// File: rtl/input_port_buffer.sv
// Per-port ingress buffer: flit FIFO, header mask extraction and request/transfer FSM for the 4-port switch.
// Optional cut-through head gating is enabled with `define IPB_CUT_THROUGH_EN (default: store-and-forward).

package packet_pkg;
  localparam int ADDR_WIDTH = 4;
endpackage

module input_port_buffer
  import packet_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  port_req,
  output logic [ADDR_WIDTH-1:0] port_dst,
  input  logic                  grant,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [7:0]            drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

  state_t                state_q, state_d;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                  grant_q;
  logic                  empty, full, push, pop, drop_inc, head_ready;
  logic                  head_sop, head_eop;
  logic [DATA_W-1:0]     head_data;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  assign {head_sop, head_eop, head_data} = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: storage has no reset; emptiness is tracked by the pointers, so stale
  // entries are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {in_sop, in_eop, in_data};
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state_q  <= IDLE;
      dst_q    <= '0;
      grant_q  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      state_q <= state_d;
      dst_q   <= dst_d;
      grant_q <= grant;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef IPB_CUT_THROUGH_EN
  assign head_ready = !empty;
`else
  logic [PTR_W:0] pkt_cnt;
  logic           push_eop, pop_eop;

  assign push_eop = push && in_eop;
  assign pop_eop  = pop && head_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (push_eop && !pop_eop) begin
      pkt_cnt <= pkt_cnt + (PTR_W+1)'(1);
    end else if (pop_eop && !push_eop) begin
      pkt_cnt <= pkt_cnt - (PTR_W+1)'(1);
    end
  end

  // Only whole packets are offered to the arbiter.
  assign head_ready = (pkt_cnt != '0);
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    pop       = 1'b0;
    out_valid = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (head_ready) begin
          if (!head_sop || head_data[ADDR_WIDTH-1:0] == '0) begin
            state_d = DROP;
          end else begin
            state_d = REQ;
            dst_d   = head_data[ADDR_WIDTH-1:0];
          end
        end
      end
      REQ: begin
        if (grant) state_d = XFER;
      end
      XFER: begin
        // grant_q mirrors the arbiter's registered path select.
        out_valid = grant_q && !empty;
        pop       = out_valid;
        if (pop && head_eop) state_d = IDLE;
      end
      DROP: begin
        pop = !empty;
        if (pop && head_eop) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign port_req = (state_q == REQ) || (state_q == XFER);
  assign port_dst = port_req ? dst_q : '0;

  assign out_data = empty ? '0 : head_data;
  assign out_sop  = !empty && head_sop;
  assign out_eop  = !empty && head_eop;

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed latency/grant/drop/fill/reset
// scenarios plus randomized traffic scored against a packet-level queue model.
`timescale 1ns/1ps

module tb_input_port_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } flit_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              port_req;
  logic [3:0]        port_dst;
  logic              grant = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic [7:0]        drop_cnt;

  input_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .port_req(port_req), .port_dst(port_dst), .grant(grant),
    .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: packets the buffer must forward, in order, and how many it must drop.
  flit_t      tx_q[$];
  flit_t      pkt_buf[$];
  flit_t      exp_q[$];
  logic [3:0] mask_q[$];
  bit         gnt_script[$];
  int         exp_drop = 0;

  int gmode = 0;     // 0 grant on request, 1 random, 2 never, 3 scripted
  int vprob = 100;
  int cyc = 0, push_cyc = 0, req_rise_cyc = 0, ov_cyc = 0, rise_cnt = 0;
  int ov_len = 0;
  logic [31:0] ov_log = '0;
  bit req_prev = 0, held = 0;

  task automatic build_pkt(input int kind, input int len, input logic [3:0] mask);
    flit_t f;
    pkt_buf.delete();
    for (int i = 0; i < len; i++) begin
      f.data = $urandom;
      f.sop  = (i == 0) && (kind != 2);
      f.eop  = (i == len - 1);
      if (i == 0 && kind != 2) f.data[3:0] = (kind == 1) ? 4'h0 : mask;
      pkt_buf.push_back(f);
      if (kind == 0) exp_q.push_back(f);
    end
    if (kind == 0) mask_q.push_back(mask);
    else if (exp_drop < 255) exp_drop++;
  endtask

  task automatic send_pkt(input int kind, input int len, input logic [3:0] mask);
    build_pkt(kind, len, mask);
    foreach (pkt_buf[i]) tx_q.push_back(pkt_buf[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(tx_q.size() == 0 && exp_q.size() == 0 && !port_req && int'(drop_cnt) == exp_drop)
           && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
  endtask

  // Per-cycle monitor and driver: scores outputs, then drives grant and input flits.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_valid = 1'b0;
      grant    = 1'b0;
      req_prev = 1'b0;
      held     = 1'b0;
    end else begin
      if (port_req && !req_prev) begin
        rise_cnt++;
        req_rise_cyc = cyc;
        ov_log = '0;
        ov_len = 0;
        if (mask_q.size() == 0) check("req_without_packet", 64'd1, 64'd0);
        else check("port_dst", 64'(port_dst), 64'(mask_q[0]));
      end
      if (!port_req) check("port_dst_idle", 64'(port_dst), 64'd0);
      if (port_req) begin
        ov_log = {ov_log[30:0], out_valid};
        ov_len++;
      end
      if (out_valid) begin
        check("out_valid_needs_grant_q", 64'(grant), 64'd1);
        if (exp_q.size() == 0) begin
          check("out_unexpected", 64'd1, 64'd0);
        end else begin
          check("out_flit", 64'({out_sop, out_eop, out_data}), 64'(exp_q[0]));
          if (exp_q[0].eop && mask_q.size() != 0) void'(mask_q.pop_front());
          void'(exp_q.pop_front());
        end
        if (out_sop) ov_cyc = cyc;
      end
      req_prev = port_req;

      case (gmode)
        0:       grant = port_req;
        1:       grant = port_req && ($urandom_range(0, 99) < 60);
        2:       grant = 1'b0;
        default: begin
          grant = 1'b0;
          if (port_req) grant = (gnt_script.size() != 0) ? gnt_script.pop_front() : 1'b1;
        end
      endcase

      if (tx_q.size() != 0 && (held || $urandom_range(0, 99) < vprob)) begin
        in_valid = 1'b1;
        {in_sop, in_eop, in_data} = tx_q[0];
        held = !in_ready;
        if (in_ready) begin
          void'(tx_q.pop_front());
          push_cyc = cyc;
        end
      end else begin
        in_valid = 1'b0;
        held     = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_port_req"}, 64'(port_req), 64'd0);
    check({tag, "_port_dst"}, 64'(port_dst), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_head"}, 64'({out_sop, out_eop, out_data}), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rise0, n, kind, len;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);

    // Single-flit packet: request two cycles after push, data one cycle later.
    gmode = 0; vprob = 100;
    send_pkt(0, 1, 4'b0100);
    wait_drain("t1_drain", 50);
    check("t1_req_latency", 64'(req_rise_cyc - push_cyc), 64'd2);
    check("t1_out_latency", 64'(ov_cyc - push_cyc), 64'd3);
    check("t1_req_cycles", 64'(ov_len), 64'd2);

    // Four flits, grant delayed three cycles then held.
    gnt_script = '{0, 0, 0, 1, 1, 1, 1, 1};
    gmode = 3;
    send_pkt(0, 4, 4'b0011);
    wait_drain("t2_drain", 80);
    check("t2_valid_pattern", 64'(ov_log[7:0]), 64'b00001111);
    check("t2_req_cycles", 64'(ov_len), 64'd8);

    // Five flits with grant on 2, off 2, on again.
    gnt_script = '{1, 1, 0, 0, 1, 1, 1, 1};
    send_pkt(0, 5, 4'b1001);
    wait_drain("t3_drain", 80);
    check("t3_valid_pattern", 64'(ov_log[7:0]), 64'b01100111);
    check("t3_req_cycles", 64'(ov_len), 64'd8);

    // Zero-mask header is dropped without a request; next packet goes through.
    gmode = 0;
    rise0 = rise_cnt;
    send_pkt(1, 2, 4'b0000);
    send_pkt(0, 3, 4'b1000);
    wait_drain("t4_drain", 80);
    check("t4_requests", 64'(rise_cnt - rise0), 64'd1);
    check("t4_drop_cnt", 64'(drop_cnt), 64'd1);

    // Fill to DEPTH with no grant: ninth flit must be held off.
    gmode = 2;
    send_pkt(0, 4, 4'b0001);
    send_pkt(0, 4, 4'b0110);
    send_pkt(0, 1, 4'b0010);
    n = 0;
    while (in_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    wait_cycles(2);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_held_flits", 64'(tx_q.size()), 64'd1);

    // Grant, then reset in the middle of the transfer.
    gmode = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("fill_transfer_started", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tx_q.delete(); exp_q.delete(); mask_q.delete(); gnt_script.delete();
    exp_drop = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(4);
    check_reset_outputs("post_reset");

`ifdef IPB_CUT_THROUGH_EN
    // Header alone triggers a request; starving the input makes bubbles.
    gmode = 0;
    build_pkt(0, 4, 4'b0010);
    tx_q.push_back(pkt_buf[0]);
    wait_cycles(6);
    check("ct_req_before_eop", 64'(port_req), 64'd1);
    check("ct_bubble", 64'(out_valid), 64'd0);
    for (int i = 1; i < 4; i++) tx_q.push_back(pkt_buf[i]);
    wait_drain("ct_drain", 80);
`endif

    // Randomized mixed traffic with a random grant pattern.
    gmode = 1; vprob = 70;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 7) ? 0 : (kind < 9 ? 1 : 2);
      len  = $urandom_range(1, DEPTH);
      send_pkt(kind, len, 4'($urandom_range(1, 15)));
    end
    wait_drain("rand_drain", 6000);
    check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

    // Drop counter saturates at 255.
    gmode = 0; vprob = 100;
    for (int p = 0; p < 258; p++) send_pkt(($urandom_range(0, 1) == 0) ? 1 : 2, 1, 4'h0);
    wait_drain("sat_drain", 3000);
    check("drop_cnt_saturated", 64'(drop_cnt), 64'd255);
    check("final_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_port_buffer.md
# input_port_buffer

Per-port ingress stage of the 4-port switch, instantiated once per input port and placed directly upstream of the all-or-nothing output arbiter. It buffers incoming flits in a FIFO and extracts the one-hot/multicast destination mask from each packet header. It drives one bit of the arbiter's `port_reqs` and the matching `portN_dst` until granted. It then streams the packet into the crossbar on the cycles the arbiter's registered path is valid.

## Interface
- `DATA_W`, 32, payload width of one flit
- `DEPTH`, 8, FIFO depth in flits; power of two, ≥2
- `ADDR_WIDTH`, from `packet_pkg`, width of the destination mask (4)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  upstream flit valid
- `in_ready`  out  1  FIFO can accept a flit (`!full`)
- `in_data`  in  DATA_W  flit payload; on SOP flit, `in_data[ADDR_WIDTH-1:0]` is the destination mask
- `in_sop` / `in_eop`  in  1 each  first / last flit of packet (both high = single-flit packet)
- `port_req`  out  1  request to arbiter
- `port_dst`  out  ADDR_WIDTH  latched destination mask of the head packet
- `grant`  in  1  this port's bit of arbiter `grant_bus` (combinational)
- `out_valid`  out  1  flit presented to crossbar this cycle
- `out_data`  out  DATA_W  head flit payload
- `out_sop` / `out_eop`  out  1 each  head flit markers
- `drop_cnt`  out  8  count of dropped packets, saturating at 255

## Operation
- FIFO entries are `{sop, eop, data}`. Push on `in_valid && in_ready`; `in_valid` while full is ignored (held by upstream).
- `pkt_cnt` counts complete packets in the FIFO (range 0..DEPTH):
  - +1 on push of an EOP flit; −1 on pop of an EOP flit.
  - Simultaneous push-EOP and pop-EOP leaves it unchanged.
- Head-ready condition:
  - Store-and-forward (default): `pkt_cnt != 0`.
  - Cut-through: FIFO not empty.
- `grant_q` is `grant` registered one cycle, matching the arbiter's registered `mux_sel`/`active`.
- FSM states IDLE, REQ, XFER, DROP:
  - **IDLE:** `port_req=0`, `port_dst=0`. When head-ready:
    - Head not SOP → DROP (malformed fragment).
    - Head mask == 0 → DROP.
    - Otherwise latch the mask into `port_dst` and go to REQ.
  - **REQ:** `port_req=1`, `port_dst` held. `grant==1` → XFER.
  - **XFER:** `port_req=1`, `port_dst` held.
    - `out_valid = grant_q && !empty`; pop on `out_valid`.
    - Pop of EOP → IDLE.
    - If `grant_q` drops mid-packet, the flit is held (not popped) until `grant_q` returns.
  - **DROP:** pop one flit per cycle while not empty, with no `out_valid`.
    - Pop of EOP → IDLE and `drop_cnt` increments (saturating).
    - A headerless fragment is discarded up to and including its EOP.
- `port_req` and `port_dst` are registered, decoded from the state register.
- `out_data`, `out_sop` and `out_eop` always reflect the FIFO head. They are meaningful only when `out_valid`.
- Multicast masks (several bits set) pass through unchanged. The arbiter performs the all-or-nothing check.

## Timing
- Reset values:
  - Outputs: `in_ready=1`, `port_req=0`, `port_dst=0`, `out_valid=0`, `out_*=0`, `drop_cnt=0`.
  - Internal: FSM in IDLE, FIFO empty, `pkt_cnt=0`, `grant_q=0`.
- Reset asserted mid-packet discards all FIFO contents and the in-flight packet immediately.
- Single-flit packet into an empty buffer, store-and-forward:
  - Push at cycle 0.
  - `port_req` high at cycle 2.
  - Grant at cycle 2.
  - `out_valid` at cycle 3.
- Cut-through removes no cycles for single-flit packets; for long packets it allows requesting before the EOP flit has arrived.
- `port_req` stays high through the cycle the EOP flit is popped. The arbiter therefore reserves one trailing path cycle.
- `port_req` is low for at least one cycle between packets (IDLE).
- An N-flit packet with continuous `grant_q` completes in N cycles of XFER.
- Full FIFO with simultaneous push and pop: push is blocked (`in_ready=0`) and the pop proceeds.

## Configuration
- `IPB_CUT_THROUGH_EN`:
  - Defined: head-ready is FIFO not empty. In XFER an empty FIFO mid-packet produces bubbles (`out_valid=0`) while `port_req` stays high. DROP also waits on empty.
  - Undefined: store-and-forward gating on `pkt_cnt`. A packet longer than DEPTH with the FIFO full and `pkt_cnt==0` is a stall; upstream must not send packets longer than DEPTH.

## Test plan
- Single-flit packet, mask 4'b0100, grant tied to `port_req` → `port_req` at cycle 2, `port_dst`=4'b0100, one `out_valid` at cycle 3 with sop=eop=1, back to IDLE.
- 4-flit packet, mask 4'b0011, grant delayed 3 cycles then held → 4 consecutive `out_valid` cycles in order, data matches pushed payloads.
- Grant high for 2 cycles, low for 2, high again during a 5-flit packet → flits 0–1 sent, 2 cycles of no `out_valid`, remaining 3 sent; no loss or duplication.
- Header with mask 4'b0000 followed by a valid packet → no `port_req` for the first packet, `drop_cnt`=1, second packet forwarded normally.
- Fill the FIFO to DEPTH → `in_ready`=0; assert reset mid-transfer → all outputs return to reset values and the FIFO is empty.
- With `IPB_CUT_THROUGH_EN`: push header only → `port_req` rises before EOP arrives; starve the input → bubbles with `port_req` held.
